seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, then a sign-fix cycle.
// Define DIVIDER_SIGNED_EN for two's-complement operands; by default operands are unsigned.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;      // partial remainder; always below the divisor
  logic [WIDTH-1:0] quo;      // dividend bits shift out as quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic             neg_q, neg_r;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;

`ifdef DIVIDER_SIGNED_EN
  assign a_neg = A[WIDTH-1];
  assign b_neg = B[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (B == '0) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      Q     <= '0;
      R     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (B == '0) begin
              Q   <= '1;
              R   <= A;
              dbz <= 1'b1;
            end
          end
        end
        CALC: begin
          // Restore by keeping the shifted value when the trial subtraction borrows.
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          Q   <= neg_q ? -quo : quo;
          R   <= neg_r ? -rem : rem;
          dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider: the driver queues reference results,
// a negedge monitor compares them (plus latency and busy length) whenever done pulses.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B;
  logic         busy, done, dbz;
  logic [W-1:0] Q, R;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int busy_run = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division on 64-bit values, truncating toward zero.
  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint x, y, q, r;
`ifdef DIVIDER_SIGNED_EN
    x = longint'($signed(a));
    y = longint'($signed(b));
`else
    x = longint'({32'd0, a});
    y = longint'({32'd0, b});
`endif
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else begin
      q = x / y;
      r = x % y;
      e.q = q[W-1:0]; e.r = r[W-1:0]; e.dbz = 1'b0; e.lat = W + 1;
    end
    e.acc = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
    A = a; B = b; start = 1'b1;
    e = ref_div(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_q"},    64'(Q),    64'd0);
    check({tag, "_r"},    64'(R),    64'd0);
    check({tag, "_dbz"},  64'(dbz),  64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient",  64'(Q),           64'(e.q));
          check("remainder", 64'(R),           64'(e.r));
          check("dbz",       64'(dbz),         64'(e.dbz));
          check("latency",   64'(cyc - e.acc), 64'(e.lat));
          check("busy_len",  64'(busy_run),    64'(e.lat));
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(32'd1296, 32'd36);
    issue(-32'sd1296, 32'd36);
    issue(-32'sd37, 32'd36);
    issue(32'd37, -32'sd36);
    issue(32'd7, 32'd0);
    issue(32'd36, 32'd6);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    issue(32'hFFFF_FFFF, 32'd1);
    issue(32'd5, 32'd9);

    // Second start while busy must be dropped.
    issue(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    A = 32'd1; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // start raised exactly during the done cycle must be dropped as well.
    issue(32'd20, 32'd3);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("done_timeout", 64'd1, 64'd0);
    A = 32'd5; B = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Abort in the middle of an operation.
    issue(32'd1296, 32'd36);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_cleared("abort");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd1296, 32'd36);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(a, b);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
